tob_serializer: RTL and testbench
=================================

# tob_serializer

Top-of-book serializer directly downstream of `order_book_engine` in the 250 MHz domain. It snapshots best bid/ask on each book update and drops updates identical to the last queued snapshot. It coalesces updates that arrive while a message is in flight, keeping only the newest. It emits each snapshot as a fixed 26-byte big-endian message on a valid/ready byte stream toward the TX FIFO and CDC.

## Interface
Parameters:
- `HDR_BYTE`, 8'hB0: constant first byte of every message.
- `SUPPRESS_DUP`, 1'b1: 1 drops updates equal to the last queued snapshot; 0 sends every update.

Ports:
- `clkIn`  in  1  250 MHz book clock
- `rstBIn`  in  1  asynchronous, active-low reset
- `bookValidIn`  in  1  one-cycle strobe; snapshot inputs valid
- `bidIn`  in  bookLevelType  best bid, {price[31:0], shares[63:0]}
- `askIn`  in  bookLevelType  best ask
- `txDataOut`  out  8  message byte
- `txValidOut`  out  1  `txDataOut` valid
- `txLastOut`  out  1  final byte (byte 25) of message
- `txReadyIn`  in  1  downstream accepts byte when high with `txValidOut`
- `coalesceCntOut`  out  16  saturating count of snapshots overwritten in pending before send

## Operation
- Message layout, bytes 0..25: `HDR_BYTE`, seq[7:0], bid.price (4 B), bid.shares (8 B), ask.price (4 B), ask.shares (8 B). All fields MSB first.
- Registers:
  - active: snapshot being sent, plus its seq.
  - pending: one snapshot plus a valid flag.
  - lastQ: most recently queued snapshot, used for dedup.
  - byteCnt: 0..25.
  - seq: 8-bit counter.
- FSM:
  - IDLE: on a non-duplicate `bookValidIn`, load active, stamp seq, seq += 1, go to SEND.
  - SEND: on each handshake (`txValidOut & txReadyIn`), byteCnt += 1. On handshake at byteCnt = 25:
    - pending valid: load pending into active, clear the pending flag, stamp seq, stay in SEND, byteCnt = 0.
    - otherwise: go to IDLE.
- Dedup: an update is a duplicate when `SUPPRESS_DUP` = 1 and {bid, ask} equals lastQ. Duplicates change nothing. A non-duplicate update writes lastQ.
- Update arrives in SEND:
  - Written to pending.
  - If pending was already valid, the older snapshot is discarded and `coalesceCntOut` increments, saturating at 16'hFFFF.
- Simultaneous update and final-byte handshake:
  - Pending valid: the old pending moves to active; the new update becomes pending; no coalesce is counted.
  - Pending empty: the update loads active directly.
- seq wraps 255 -> 0. seq is stamped when a snapshot enters active, not when it arrives.
- Reset values:
  - all outputs 0
  - seq 0
  - FSM IDLE
  - pending flag 0
  - lastQ all-zero, so an all-zero snapshot right after reset is suppressed.
- Reset mid-message aborts it immediately. No `txLastOut` is issued and the message is not resumed.

## Timing
- Latency: `bookValidIn` at cycle N in IDLE gives `txValidOut` = 1 with byte 0 at N+1.
- Back-to-back messages: final-byte handshake at cycle M with pending valid gives byte 0 of the next message at M+1. There is no idle gap.
- All outputs are registered. `txDataOut` and `txLastOut` are stable while `txValidOut & !txReadyIn`.
- `txValidOut` never drops without a handshake, except on reset.
- With `txReadyIn` held high, a message takes exactly 26 cycles.
- The block never stalls `bookValidIn`; there is no ready output.

## Structure
- Shared package (with the existing book types):
  - `bookLevelType` {price[31:0], shares[63:0]}
  - `TOB_MSG_BYTES` = 26
  - `TOB_HDR_BYTE` default
- Byte selection is a mux over a 208-bit packed message formed from active.
- Single module; no sub-module needed.

## Test plan
- Single update, bid {100, 5}, ask {101, 7}, `txReadyIn` = 1 -> bytes B0, 00, 00 00 00 64, 00×7 05, 00 00 00 65, 00×7 07 on consecutive cycles starting N+1. `txLastOut` high only on byte 25.
- Same snapshot sent twice, 40 cycles apart -> one message. With `SUPPRESS_DUP` = 0 -> two messages, seq 00 then 01.
- Three distinct updates during one message (A in flight, then B, C, D) -> A, then D with seq+1. `coalesceCntOut` = 2.
- Random `txReadyIn` at 50% -> byte sequence identical to the always-ready case. Output is held stable during stalls.
- Update on the same cycle as the final-byte handshake, pending empty -> next message byte 0 on the following cycle.
- 257 distinct updates with idle gaps -> seq wraps FF -> 00 -> 01. Assert `rstBIn` low mid-message -> `txValidOut` goes 0 asynchronously; the next update after release sends seq 00.

Source files
------------

// File: rtl/tob_serializer_pkg.sv
// -----------------------------------------------------------------------------
// tob_serializer_pkg
//
// Shared types and constants for the top-of-book serializer.
//   bookLevelType  : one book level, {price[31:0], shares[63:0]}
//   tob_snap_t     : a full top-of-book snapshot, {bid, ask}
//   tob_state_e    : serializer FSM states
//   TOB_MSG_BYTES  : bytes per wire message (header + seq + snapshot)
//   TOB_HDR_BYTE   : default constant first byte of every message
//   tob_msg_byte() : selects one byte of the big-endian wire message
// -----------------------------------------------------------------------------
package tob_serializer_pkg;

  typedef struct packed {
    logic [31:0] price;
    logic [63:0] shares;
  } bookLevelType;

  typedef struct packed {
    bookLevelType bid;
    bookLevelType ask;
  } tob_snap_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tob_state_e;

  localparam int          TOB_MSG_BYTES = 26;
  localparam int          TOB_MSG_BITS  = TOB_MSG_BYTES * 8;
  localparam logic [7:0]  TOB_HDR_BYTE  = 8'hB0;
  localparam logic [4:0]  TOB_LAST_IDX  = 5'(TOB_MSG_BYTES - 1);

  // Byte idx of the message {hdr, seq, bid.price, bid.shares, ask.price,
  // ask.shares}, byte 0 being the most significant. Shifting the wanted byte
  // to the top keeps the select a plain constant slice.
  function automatic logic [7:0] tob_msg_byte(
    input logic [7:0] hdr,
    input logic [7:0] seq,
    input tob_snap_t  snap,
    input logic [4:0] idx
  );
    logic [TOB_MSG_BITS-1:0] msg;
    msg = {hdr, seq, snap} << {idx, 3'b000};
    return msg[TOB_MSG_BITS-1 -: 8];
  endfunction

endpackage : tob_serializer_pkg

// File: rtl/tob_serializer.sv
// -----------------------------------------------------------------------------
// tob_serializer
//
// Snapshots best bid/ask on every book update and streams each snapshot as a
// 26-byte big-endian message on a valid/ready byte interface. Updates equal to
// the last queued snapshot are dropped (when SUPPRESS_DUP = 1). Updates that
// arrive while a message is in flight are held in a single pending slot; a
// newer update overwrites an older pending one and is counted as coalesced.
//
// Parameters:
//   HDR_BYTE      constant first byte of every message
//   SUPPRESS_DUP  1: drop updates equal to the last queued snapshot
//
// Ports:
//   clkIn          in   book clock
//   rstBIn         in   asynchronous active-low reset
//   bookValidIn    in   one-cycle strobe, bidIn/askIn valid
//   bidIn, askIn   in   best bid / best ask levels
//   txDataOut      out  message byte
//   txValidOut     out  txDataOut valid
//   txLastOut      out  final byte of the message
//   txReadyIn      in   downstream accepts the byte when high with txValidOut
//   coalesceCntOut out  saturating count of overwritten pending snapshots
// -----------------------------------------------------------------------------
module tob_serializer
  import tob_serializer_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE     = TOB_HDR_BYTE,
  parameter bit         SUPPRESS_DUP = 1'b1
) (
  input  logic         clkIn,
  input  logic         rstBIn,
  input  logic         bookValidIn,
  input  bookLevelType bidIn,
  input  bookLevelType askIn,
  output logic [7:0]   txDataOut,
  output logic         txValidOut,
  output logic         txLastOut,
  input  logic         txReadyIn,
  output logic [15:0]  coalesceCntOut
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  tob_state_e  state_q,      state_d;
  tob_snap_t   active_q,     active_d;      // snapshot currently on the wire
  logic [7:0]  active_seq_q, active_seq_d;  // seq stamped on active
  tob_snap_t   pend_q,       pend_d;        // newest snapshot waiting to send
  logic        pend_vld_q,   pend_vld_d;
  tob_snap_t   last_q,       last_d;        // most recently queued snapshot
  logic [4:0]  byte_cnt_q,   byte_cnt_d;    // index of the byte on txDataOut
  logic [7:0]  seq_q,        seq_d;         // next seq to stamp
  logic [15:0] coal_q,       coal_d;
  logic [7:0]  tx_data_q,    tx_data_d;
  logic        tx_valid_q,   tx_valid_d;
  logic        tx_last_q,    tx_last_d;

  tob_snap_t   upd_snap;
  logic        is_dup;
  logic        upd;
  logic        hs;
  logic        final_hs;

  assign upd_snap = {bidIn, askIn};
  assign is_dup   = SUPPRESS_DUP && (upd_snap == last_q);
  assign upd      = bookValidIn && !is_dup;
  assign hs       = tx_valid_q && txReadyIn;
  assign final_hs = hs && (byte_cnt_q == TOB_LAST_IDX);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    active_d     = active_q;
    active_seq_d = active_seq_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    last_d       = last_q;
    byte_cnt_d   = byte_cnt_q;
    seq_d        = seq_q;
    coal_d       = coal_q;

    // Every accepted update becomes the reference for dedup, whether it goes
    // straight to active or waits in pending.
    if (upd) begin
      last_d = upd_snap;
    end

    case (state_q)
      ST_IDLE: begin
        if (upd) begin
          active_d     = upd_snap;
          active_seq_d = seq_q;
          seq_d        = seq_q + 8'd1;
          byte_cnt_d   = '0;
          state_d      = ST_SEND;
        end
      end

      ST_SEND: begin
        if (final_hs) begin
          byte_cnt_d = '0;
          if (pend_vld_q) begin
            // Older pending goes out next; a simultaneous update takes its
            // place in pending without counting as a coalesce.
            active_d     = pend_q;
            active_seq_d = seq_q;
            seq_d        = seq_q + 8'd1;
            pend_vld_d   = upd;
            if (upd) begin
              pend_d = upd_snap;
            end
          end else if (upd) begin
            active_d     = upd_snap;
            active_seq_d = seq_q;
            seq_d        = seq_q + 8'd1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          if (hs) begin
            byte_cnt_d = byte_cnt_q + 5'd1;
          end
          if (upd) begin
            pend_d     = upd_snap;
            pend_vld_d = 1'b1;
            if (pend_vld_q && (coal_q != 16'hFFFF)) begin
              coal_d = coal_q + 16'd1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next state so they can be registered while
    // still presenting byte 0 the cycle after the snapshot is loaded. With no
    // handshake nothing above changes, so the byte holds during a stall.
    tx_valid_d = (state_d == ST_SEND);
    tx_last_d  = tx_valid_d && (byte_cnt_d == TOB_LAST_IDX);
    tx_data_d  = tx_valid_d ? tob_msg_byte(HDR_BYTE, active_seq_d, active_d, byte_cnt_d)
                            : 8'h00;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state_q      <= ST_IDLE;
      active_q     <= '0;
      active_seq_q <= '0;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      last_q       <= '0;
      byte_cnt_q   <= '0;
      seq_q        <= '0;
      coal_q       <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_last_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      active_seq_q <= active_seq_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      last_q       <= last_d;
      byte_cnt_q   <= byte_cnt_d;
      seq_q        <= seq_d;
      coal_q       <= coal_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      tx_last_q    <= tx_last_d;
    end
  end

  assign txDataOut      = tx_data_q;
  assign txValidOut     = tx_valid_q;
  assign txLastOut      = tx_last_q;
  assign coalesceCntOut = coal_q;

endmodule : tob_serializer

// File: tb/tb_tob_serializer.sv
// -----------------------------------------------------------------------------
// tb_tob_serializer
//
// Self-checking bench for tob_serializer. Expected messages are built from the
// snapshot fields and queued when stimulus is driven; a monitor pops and
// compares every accepted byte and checks that stalled outputs hold.
// A second instance with SUPPRESS_DUP = 0 covers the no-dedup mode.
// -----------------------------------------------------------------------------
module tb_tob_serializer;
  import tob_serializer_pkg::*;

  localparam logic [7:0] HDR = 8'hB0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         book_valid;
  bookLevelType bid;
  bookLevelType ask;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_last;
  logic         tx_ready;
  logic [15:0]  coal;

  logic         nd_book_valid;
  logic [7:0]   nd_data;
  logic         nd_valid;
  logic         nd_last;
  logic         nd_ready = 1'b1;
  logic [15:0]  nd_coal;

  always #5 clk = ~clk;

  tob_serializer dut (
    .clkIn          (clk),
    .rstBIn         (rst_n),
    .bookValidIn    (book_valid),
    .bidIn          (bid),
    .askIn          (ask),
    .txDataOut      (tx_data),
    .txValidOut     (tx_valid),
    .txLastOut      (tx_last),
    .txReadyIn      (tx_ready),
    .coalesceCntOut (coal)
  );

  tob_serializer #(.HDR_BYTE(8'hB0), .SUPPRESS_DUP(1'b0)) dut_nd (
    .clkIn          (clk),
    .rstBIn         (rst_n),
    .bookValidIn    (nd_book_valid),
    .bidIn          (bid),
    .askIn          (ask),
    .txDataOut      (nd_data),
    .txValidOut     (nd_valid),
    .txLastOut      (nd_last),
    .txReadyIn      (nd_ready),
    .coalesceCntOut (nd_coal)
  );

  // ---------------------------------------------------------------------------
  // Checking infrastructure
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_byte_t;

  exp_byte_t  sb_q[$];
  logic [7:0] exp_seq = 8'h00;
  bit         rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bookLevelType lvl(input logic [31:0] p, input logic [63:0] s);
    bookLevelType l;
    l.price  = p;
    l.shares = s;
    return l;
  endfunction

  function automatic void push_b(input logic [7:0] d, input logic l);
    exp_byte_t e;
    e.data = d;
    e.last = l;
    sb_q.push_back(e);
  endfunction

  // Expected wire image of one message, field by field, MSB first.
  function automatic void push_msg(input bookLevelType b, input bookLevelType a);
    push_b(HDR, 1'b0);
    push_b(exp_seq, 1'b0);
    for (int k = 3; k >= 0; k--) push_b(b.price[8*k +: 8], 1'b0);
    for (int k = 7; k >= 0; k--) push_b(b.shares[8*k +: 8], 1'b0);
    for (int k = 3; k >= 0; k--) push_b(a.price[8*k +: 8], 1'b0);
    for (int k = 7; k >= 0; k--) push_b(a.shares[8*k +: 8], k == 0);
    exp_seq = exp_seq + 8'd1;
  endfunction

  // Ready driver: always-ready unless the random mode is on.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare accepted bytes against the scoreboard, check hold on stall.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_on_stall", 64'({tx_valid, tx_last, tx_data}),
              64'({1'b1, prev_last, prev_data}));
      end
      if (tx_valid && tx_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none @%0t", tx_data, $time);
        end else begin
          exp_byte_t e;
          e = sb_q.pop_front();
          check("msg_byte", 64'({tx_last, tx_data}), 64'({e.last, e.data}));
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_last  = tx_last;
    end
  end

  // Monitor for the no-dedup instance: count messages and record their seq.
  int         nd_idx  = 0;
  int         nd_msgs = 0;
  logic [7:0] nd_seqs[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      nd_idx = 0;
    end else if (nd_valid) begin
      if (nd_idx == 1) nd_seqs.push_back(nd_data);
      if (nd_last) begin
        nd_msgs++;
        nd_idx = 0;
      end else begin
        nd_idx++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_update(input bookLevelType b, input bookLevelType a);
    @(posedge clk);
    #1;
    bid        = b;
    ask        = a;
    book_valid = 1'b1;
    @(posedge clk);
    #1;
    book_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    bit done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !tx_valid) done = 1'b1;
    end
    check("drain_in_time", 64'(done), 64'd1);
    if (!done) sb_q.delete();
  endtask

  // Returns on the negedge of the cycle whose posedge accepts the final byte.
  task automatic wait_last(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && tx_last) seen = 1'b1;
    end
    check("final_byte_seen", 64'(seen), 64'd1);
  endtask

  typedef struct {
    bookLevelType bid;
    bookLevelType ask;
    logic         sent;
    logic [7:0]   seq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bookLevelType ba, aa, bd, ad;

    // Reset-suppressed all-zero, then dedup/no-dedup mix; seq follows sends.
    vecs[0] = '{bid: lvl(32'd0,   64'd0), ask: lvl(32'd0,   64'd0), sent: 1'b0, seq: 8'h00};
    vecs[1] = '{bid: lvl(32'd100, 64'd5), ask: lvl(32'd101, 64'd7), sent: 1'b1, seq: 8'h00};
    vecs[2] = '{bid: lvl(32'd100, 64'd5), ask: lvl(32'd101, 64'd7), sent: 1'b0, seq: 8'h00};
    vecs[3] = '{bid: lvl(32'd100, 64'd6), ask: lvl(32'd101, 64'd7), sent: 1'b1, seq: 8'h01};
    vecs[4] = '{bid: lvl(32'd100, 64'd5), ask: lvl(32'd101, 64'd7), sent: 1'b1, seq: 8'h02};
    vecs[5] = '{bid: lvl(32'hDEADBEEF, 64'h0123_4567_89AB_CDEF),
                ask: lvl(32'hFFFFFFFF, 64'hFFFF_FFFF_FFFF_FFFF), sent: 1'b1, seq: 8'h03};
    vecs[6] = '{bid: lvl(32'd0,   64'd0), ask: lvl(32'd0,   64'd0), sent: 1'b1, seq: 8'h04};

    rst_n         = 1'b0;
    book_valid    = 1'b0;
    nd_book_valid = 1'b0;
    bid           = '0;
    ask           = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_valid", 64'(tx_valid), 64'd0);
    check("reset_last",  64'(tx_last),  64'd0);
    check("reset_data",  64'(tx_data),  64'd0);
    check("reset_coal",  64'(coal),     64'd0);

    // Table: single updates with always-ready; byte 0 appears the cycle after.
    foreach (vecs[i]) begin
      if (vecs[i].sent) begin
        exp_seq = vecs[i].seq;
        push_msg(vecs[i].bid, vecs[i].ask);
      end
      drive_update(vecs[i].bid, vecs[i].ask);
      @(negedge clk);
      check("latency_valid", 64'(tx_valid), 64'(vecs[i].sent));
      wait_drain(60);
      repeat (12) @(posedge clk);
    end

    // No-dedup instance: same snapshot twice, 40 cycles apart.
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      bid           = lvl(32'd100, 64'd5);
      ask           = lvl(32'd101, 64'd7);
      nd_book_valid = 1'b1;
      @(posedge clk);
      #1;
      nd_book_valid = 1'b0;
      repeat (40) @(posedge clk);
    end
    check("nodedup_msgs", 64'(nd_msgs), 64'd2);
    check("nodedup_seq0", 64'(nd_seqs.size() > 0 ? nd_seqs[0] : 8'hEE), 64'h00);
    check("nodedup_seq1", 64'(nd_seqs.size() > 1 ? nd_seqs[1] : 8'hEE), 64'h01);

    // Coalescing: A in flight, B, C, D arrive -> A then D, two coalesced.
    ba = lvl(32'h0000_1000, 64'd1);  aa = lvl(32'h0000_1001, 64'd2);
    bd = lvl(32'h0000_4000, 64'd4);  ad = lvl(32'h0000_4001, 64'd8);
    push_msg(ba, aa);
    push_msg(bd, ad);
    drive_update(ba, aa);
    drive_update(lvl(32'h0000_2000, 64'd2), lvl(32'h0000_2001, 64'd3));
    drive_update(lvl(32'h0000_3000, 64'd3), lvl(32'h0000_3001, 64'd5));
    drive_update(bd, ad);
    wait_last(60);
    @(negedge clk);
    check("b2b_valid", 64'(tx_valid), 64'd1);
    check("b2b_hdr",   64'(tx_data),  64'(HDR));
    wait_drain(60);
    check("coalesce_cnt", 64'(coal), 64'd2);

    // Random 50% ready: same byte stream, held stable during stalls.
    rand_ready = 1'b1;
    ba = lvl(32'h0BAD_F00D, 64'h1111_2222_3333_4444);
    aa = lvl(32'h0BAD_F00E, 64'h5555_6666_7777_8888);
    bd = lvl(32'h1234_5678, 64'h9999_AAAA_BBBB_CCCC);
    ad = lvl(32'h8765_4321, 64'hDDDD_EEEE_FFFF_0000);
    push_msg(ba, aa);
    push_msg(bd, ad);
    drive_update(ba, aa);
    repeat (5) @(posedge clk);
    drive_update(bd, ad);
    wait_drain(400);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Update on the final-byte handshake with pending empty.
    ba = lvl(32'd500, 64'd50);  aa = lvl(32'd501, 64'd51);
    bd = lvl(32'd600, 64'd60);  ad = lvl(32'd601, 64'd61);
    push_msg(ba, aa);
    push_msg(bd, ad);
    drive_update(ba, aa);
    wait_last(60);
    bid        = bd;
    ask        = ad;
    book_valid = 1'b1;
    @(posedge clk);
    #1;
    book_valid = 1'b0;
    @(negedge clk);
    check("final_upd_valid", 64'(tx_valid), 64'd1);
    check("final_upd_hdr",   64'(tx_data),  64'(HDR));
    wait_drain(60);

    // Update on the final-byte handshake with pending valid: I, J, K in order.
    push_msg(lvl(32'd700, 64'd70), lvl(32'd701, 64'd71));
    push_msg(lvl(32'd800, 64'd80), lvl(32'd801, 64'd81));
    push_msg(lvl(32'd900, 64'd90), lvl(32'd901, 64'd91));
    drive_update(lvl(32'd700, 64'd70), lvl(32'd701, 64'd71));
    repeat (4) @(posedge clk);
    drive_update(lvl(32'd800, 64'd80), lvl(32'd801, 64'd81));
    wait_last(60);
    bid        = lvl(32'd900, 64'd90);
    ask        = lvl(32'd901, 64'd91);
    book_valid = 1'b1;
    @(posedge clk);
    #1;
    book_valid = 1'b0;
    wait_drain(120);
    check("no_coalesce_on_final", 64'(coal), 64'd2);

    // 257 distinct updates with idle gaps: seq wraps through FF -> 00.
    for (int i = 0; i < 257; i++) begin
      push_msg(lvl(32'h2000_0000 + 32'(i), 64'(i)), lvl(32'h3000_0000, 64'(i * 3)));
      drive_update(lvl(32'h2000_0000 + 32'(i), 64'(i)), lvl(32'h3000_0000, 64'(i * 3)));
      wait_drain(60);
    end

    // Reset mid-message aborts it; next update after release carries seq 00.
    push_msg(lvl(32'h4444_0000, 64'd44), lvl(32'h4444_0001, 64'd45));
    drive_update(lvl(32'h4444_0000, 64'd44), lvl(32'h4444_0001, 64'd45));
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midreset_valid", 64'(tx_valid), 64'd0);
    check("midreset_last",  64'(tx_last),  64'd0);
    check("midreset_data",  64'(tx_data),  64'd0);
    check("midreset_coal",  64'(coal),     64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    exp_seq = 8'h00;
    push_msg(lvl(32'h5555_0000, 64'd55), lvl(32'h5555_0001, 64'd56));
    drive_update(lvl(32'h5555_0000, 64'd55), lvl(32'h5555_0001, 64'd56));
    wait_drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tob_serializer
